core_launcher: RTL and testbench

Host-side run controller for the matrix-multiplication array. It re-arms the per-core control units, drives their shared `status` start code, and collects their `end_process` completion flags. Once every core has finished, it reads the result region of data memory and streams it out over a valid/ready interface. It is the initiator end of the `status`/`end_process` handshake that each core's control unit responds to.

---
 rtl/core_launcher_if.sv | 30 +++
 rtl/core_launcher.sv | 176 +++++++++++++++++
 tb/tb_core_launcher.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/core_launcher_if.sv
// Launcher-side bundle: core start/finish handshake, result-memory read port
// and the valid/ready result stream.
interface core_launcher_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
);
  logic                 start;
  logic [NUM_CORES-1:0] end_process;
  logic                 core_rst;
  logic [1:0]           status;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_rdata;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, end_process, mem_rdata, out_ready,
    output core_rst, status, mem_rd_en, mem_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, end_process, mem_rdata, out_ready,
    input  core_rst, status, mem_rd_en, mem_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/core_launcher.sv
// Run controller: re-arms the cores, collects end_process, streams results.
// Optional run watchdog enabled by defining LAUNCH_TIMEOUT_EN.
module core_launcher #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int RESULT_BASE    = 0,
  parameter int RESULT_WORDS   = 9,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic clk,
  input logic rst,
  core_launcher_if.master bus
);

  // IDLE wait start | CRST core reset pulse | SETTLE flags clear | RUN collect
  // RD_ISSUE read | RD_WAIT capture | SEND hold word | DONE results delivered
  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_SETTLE, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_SEND, S_DONE
  } state_e;

  localparam int CNT_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(RESULT_WORDS - 1);

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic                 timeout_hit;
  logic [1:0]           status_d;

  logic                 core_rst_q;
  logic [1:0]           status_q;
  logic                 mem_rd_en_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    out_data_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 done_q;

`ifdef LAUNCH_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Down-counter loaded as RUN is entered; terminal count ends the run.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == S_SETTLE) begin
      tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == S_RUN) && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign timeout_hit = (state_q == S_RUN) && (tmr_q == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_CRST;
      end
      S_CRST: begin
        to_d    = 1'b0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        mask_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // The completing bit counts in the same cycle it arrives.
        mask_d = mask_q | bus.end_process;
        if (&mask_d) begin
          cnt_d   = '0;
          state_d = S_RD_ISSUE;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_SEND;
      S_SEND: begin
        if (bus.out_ready) begin
          if (cnt_q == LAST_WORD) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (bus.start) state_d = S_CRST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_d = 2'b00;
    case (state_d)
      S_RUN:   status_d = 2'b01;
      S_DONE:  status_d = {1'b1, to_d};
      default: status_d = 2'b00;
    endcase
  end

  // Outputs are registered from the next state so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_q  <= 1'b0;
      status_q    <= 2'b00;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      core_rst_q  <= (state_d == S_CRST);
      status_q    <= status_d;
      mem_rd_en_q <= (state_d == S_RD_ISSUE);
      if (state_d == S_RD_ISSUE) begin
        mem_addr_q <= ADDR_W'(RESULT_BASE) + ADDR_W'(cnt_d);
      end
      if (state_q == S_RD_WAIT) begin
        out_data_q <= bus.mem_rdata;
      end
      out_valid_q <= (state_d == S_SEND);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.status    = status_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_core_launcher.sv
// Directed bench for core_launcher; the watchdog scenario runs only when
// LAUNCH_TIMEOUT_EN is defined.
module tb_core_launcher;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  core_launcher_if #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(8)) bus ();

  core_launcher #(
    .NUM_CORES(4), .ADDR_W(8), .DATA_W(8),
    .RESULT_BASE(0), .RESULT_WORDS(9), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] a);
    return (a * 8'd17) ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= memf(bus.mem_addr);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] ep;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.end_process = '0;
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_status", bus.status, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_core_rst", bus.core_rst, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    rst = 1'b0;
    cyc();
    chk("idle_status", bus.status, 0);

    // Basic run: start, core flags at RUN cycles 5/9/12/20, start ignored in RUN
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("crst_pulse", bus.core_rst, 1);
    chk("crst_busy", bus.busy, 1);
    chk("crst_status", bus.status, 0);
    cyc();
    chk("settle_core_rst", bus.core_rst, 0);
    chk("settle_status", bus.status, 0);
    cyc();
    for (int k = 0; k <= 20; k++) begin
      ep = 4'b0000;
      if (k >= 5)  ep[0] = 1'b1;
      if (k >= 9)  ep[1] = 1'b1;
      if (k >= 12) ep[2] = 1'b1;
      if (k >= 20) ep[3] = 1'b1;
      bus.end_process = ep;
      bus.start = (k == 10);
      chk("run_status", bus.status, 1);
      chk("run_no_rd", bus.mem_rd_en, 0);
      chk("run_no_core_rst", bus.core_rst, 0);
      chk("run_busy", bus.busy, 1);
      cyc();
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;

    // Readout of 9 words, backpressure on word 2, start ignored in SEND of word 4
    for (int w = 0; w < 9; w++) begin
      chk("rdissue_en", bus.mem_rd_en, 1);
      chk("rdissue_addr", bus.mem_addr, w);
      chk("rdissue_valid", bus.out_valid, 0);
      bus.out_ready = (w != 2);
      cyc();
      chk("rdwait_en", bus.mem_rd_en, 0);
      chk("rdwait_valid", bus.out_valid, 0);
      cyc();
      chk("send_valid", bus.out_valid, 1);
      chk("send_data", bus.out_data, memf(8'(w)));
      chk("send_no_rd", bus.mem_rd_en, 0);
      if (w == 4) bus.start = 1'b1;
      if (w == 2) begin
        for (int j = 1; j <= 4; j++) begin
          cyc();
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, memf(8'd2));
          chk("stall_no_rd", bus.mem_rd_en, 0);
          chk("stall_addr", bus.mem_addr, 2);
        end
        bus.out_ready = 1'b1;
      end
      cyc();
      bus.start = 1'b0;
      if (w == 4) chk("send_start_ignored", bus.core_rst, 0);
    end
    chk("done_flag", bus.done, 1);
    chk("done_status", bus.status, 2);
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.out_valid, 0);
    bus.end_process = '0;
    cyc();
    chk("done_hold", bus.done, 1);
    chk("done_hold_status", bus.status, 2);

    // Relaunch from DONE with stale flags held through CRST
    bus.start = 1'b1;
    bus.end_process = 4'hF;
    cyc();
    bus.start = 1'b0;
    chk("relaunch_core_rst", bus.core_rst, 1);
    chk("relaunch_done_drop", bus.done, 0);
    chk("relaunch_status", bus.status, 0);
    cyc();
    bus.end_process = 4'h0;
    chk("relaunch_settle", bus.core_rst, 0);
    cyc();
    for (int k = 0; k <= 9; k++) begin
      chk("stale_status", bus.status, 1);
      chk("stale_no_rd", bus.mem_rd_en, 0);
      if (k == 9) bus.end_process = 4'hF;
      cyc();
    end
    chk("fresh_rd_en", bus.mem_rd_en, 1);
    chk("fresh_addr", bus.mem_addr, 0);
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk("midrst_valid_before", bus.out_valid, 1);
    chk("midrst_data_before", bus.out_data, memf(8'd0));

    // Reset while a word is pending
    rst = 1'b1;
    cyc();
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_status", bus.status, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_core_rst", bus.core_rst, 0);
    chk("midrst_done", bus.done, 0);
    rst = 1'b0;
    bus.end_process = 4'h0;
    bus.out_ready = 1'b1;

`ifdef LAUNCH_TIMEOUT_EN
    // Core 2 never finishes; watchdog ends the run after 50 RUN cycles
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    bus.end_process = 4'b1011;
    for (int k = 0; k < 50; k++) begin
      chk("to_run_status", bus.status, 1);
      chk("to_run_no_rd", bus.mem_rd_en, 0);
      cyc();
    end
    chk("to_status", bus.status, 3);
    chk("to_done", bus.done, 1);
    chk("to_no_rd", bus.mem_rd_en, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("to_hold_no_rd", bus.mem_rd_en, 0);
      chk("to_hold_status", bus.status, 3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
